tone_decoder: RTL and testbench
===============================

TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 SHALL have parameter TOL, default 1024, meaning the ±sysclk-cycle tolerance used when matching a measured half-period.
REQ-002 SHALL have parameter CNT_W, default 17, meaning the half-period counter width.
REQ-003 SHALL have port sysclk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tone_in  input  1  square wave from the piano tone generator, asynchronous to sysclk.
REQ-006 SHALL have port note  output  8  decoded full note number, 25..37, or 0 when none.
REQ-007 SHALL have port key  output  4  decoded key code, 1..13, or 0 when none.
REQ-008 SHALL have port valid  output  1  high while locked on a note.
REQ-009 SHALL have port note_strobe  output  1  one-cycle pulse on each new lock.

Function
REQ-010 SHALL synchronize tone_in through 2 flops, then detect both edges, so edge_p asserts 3 sysclk after a tone_in transition.
REQ-011 SHALL use a CNT_W-bit counter cnt: on edge_p, cnt←1; otherwise cnt←cnt+1, saturating at 131071; measured half-period = cnt value in the edge_p cycle.
REQ-012 SHALL classify the measured half-period against these sysclk half-periods, matching when |cnt−T| ≤ TOL, else no-match: 25:123648, 26:116736, 27:110336, 28:103936, 29:98304, 30:92672, 31:87552, 32:82688, 33:77824, 34:73472, 35:69376, 36:65536, 37:61824.
REQ-013 SHALL map key from note as follows: 25→6, 26→1, 27→7, 28→2, 29→8, 30→9, 31→3, 32→10, 33→4, 34→11, 35→5, 36→12, 37→13.
REQ-014 SHALL implement a state machine with states SILENT, ACQUIRE and LOCKED, plus a candidate register cand (note number, 0 = none).
REQ-015 In SILENT, on edge_p: go to ACQUIRE with cand←0.
REQ-016 In ACQUIRE, on edge_p: if the match is nonzero and equals cand, go to LOCKED, load note/key, set valid=1 and pulse note_strobe; otherwise cand←match (0 if no-match).
REQ-017 In LOCKED, on edge_p: if the match equals note, stay with no strobe; otherwise go to ACQUIRE with cand←match and valid←0, holding note/key.
REQ-018 In ACQUIRE or LOCKED, when cnt reaches 131071: go to SILENT with note=0, key=0, valid=0 and no strobe.
REQ-019 Outputs SHALL be registered and update in the cycle after edge_p (4 sysclk after the tone_in transition).
REQ-020 The first irregular half-period after a key change SHALL be absorbed by the two-consecutive-match rule; lock therefore requires ≥3 edges.
REQ-021 If edge_p and saturation occur in the same cycle, edge_p SHALL take priority.

Reset
REQ-022 While reset is asserted: state=SILENT, cand=0, cnt=0, sync flops=0, note=0, key=0, valid=0, note_strobe=0.
REQ-023 Reset mid-measurement SHALL discard all partial data; after release, re-acquire from the first edge.

Structure
REQ-024 Package tone_pkg SHALL hold the half-period table, default TOL, the note→key map and the state encoding.
REQ-025 Sub-module half_period_classifier SHALL be combinational: cnt in → matched note (0 = none) out.

Verification
REQ-026 Toggle tone_in every 87552 sysclk for 4 half-periods -> note=31, key=3, valid=1, one note_strobe, 4 cycles after the 3rd edge.
REQ-027 Lock on 25, then switch to 65536-cycle half-periods -> valid drops at the first mismatching edge; relock note=36, key=12, one strobe.
REQ-028 Use half-periods of 61824+TOL and 61824−TOL-1 -> the first matches note 37; the second gives no-match and no lock.
REQ-029 Lock on any note, then hold tone_in static -> exactly 131071 cycles after the last edge: note=0, key=0, valid=0.
REQ-030 Assert reset while LOCKED at half-count -> all outputs 0 the next cycle; relock requires 3 fresh edges.
REQ-031 Drive in-tolerance jitter of ±500 cycles on note 33 -> stays LOCKED, key=4, no extra strobes.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared constants for the piano tone decoder: note table, key map and FSM encoding.
package tone_pkg;

  localparam int NUM_NOTES     = 13;
  localparam int FIRST_NOTE    = 25;
  localparam int DEFAULT_TOL   = 1024;
  localparam int DEFAULT_CNT_W = 17;

  typedef enum logic [1:0] {
    SILENT  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Expected half-period in sysclk cycles for note FIRST_NOTE + idx.
  function automatic int half_period(input int idx);
    case (idx)
      0:       return 123648;
      1:       return 116736;
      2:       return 110336;
      3:       return 103936;
      4:       return 98304;
      5:       return 92672;
      6:       return 87552;
      7:       return 82688;
      8:       return 77824;
      9:       return 73472;
      10:      return 69376;
      11:      return 65536;
      12:      return 61824;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] note_to_key(input logic [7:0] n);
    case (n)
      8'd25:   return 4'd6;
      8'd26:   return 4'd1;
      8'd27:   return 4'd7;
      8'd28:   return 4'd2;
      8'd29:   return 4'd8;
      8'd30:   return 4'd9;
      8'd31:   return 4'd3;
      8'd32:   return 4'd10;
      8'd33:   return 4'd4;
      8'd34:   return 4'd11;
      8'd35:   return 4'd5;
      8'd36:   return 4'd12;
      8'd37:   return 4'd13;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/half_period_classifier.sv
// Combinational match of a measured half-period against the note table (0 = no match).
module half_period_classifier
  import tone_pkg::*;
#(
  parameter int TOL   = DEFAULT_TOL,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic [CNT_W-1:0] cnt,
  output logic [7:0]       match
);

  logic [NUM_NOTES-1:0] hit;
  logic [31:0]          cnt_ext;

  assign cnt_ext = 32'(cnt);

  for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_note
    localparam logic [31:0] LO = 32'(half_period(gi) - TOL);
    localparam logic [31:0] HI = 32'(half_period(gi) + TOL);
    assign hit[gi] = (cnt_ext >= LO) && (cnt_ext <= HI);
  end

  // Table windows never overlap at the default tolerance, so at most one hit is set.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (hit[i]) match = 8'(FIRST_NOTE + i);
    end
  end

endmodule

// File: rtl/tone_decoder.sv
// Measures tone_in half-periods and locks onto a note after two consecutive matches.
module tone_decoder
  import tone_pkg::*;
#(
  parameter int TOL   = DEFAULT_TOL,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       tone_in,
  output logic [7:0] note,
  output logic [3:0] key,
  output logic       valid,
  output logic       note_strobe
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       sync_reg;
  logic             edge_p;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       match;
  logic [7:0]       cand;
  state_t           state;

  // sync_reg[1:0] is the synchronizer; sync_reg[2] is the previous level for edge detect.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_reg <= '0;
      edge_p   <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], tone_in};
      edge_p   <= sync_reg[2] ^ sync_reg[1];
      if (edge_p)
        cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);
    end
  end

  half_period_classifier #(.TOL(TOL), .CNT_W(CNT_W)) u_classifier (
    .cnt   (cnt),
    .match (match)
  );

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= SILENT;
      cand        <= '0;
      note        <= '0;
      key         <= '0;
      valid       <= 1'b0;
      note_strobe <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      if (edge_p) begin
        case (state)
          SILENT: begin
            state <= ACQUIRE;
            cand  <= '0;
          end
          ACQUIRE: begin
            if (match != 8'd0 && match == cand) begin
              state       <= LOCKED;
              note        <= match;
              key         <= note_to_key(match);
              valid       <= 1'b1;
              note_strobe <= 1'b1;
            end else begin
              cand <= match;
            end
          end
          LOCKED: begin
            // Note/key are held so downstream still sees the last note while re-acquiring.
            if (match != note) begin
              state <= ACQUIRE;
              cand  <= match;
              valid <= 1'b0;
            end
          end
          default: state <= SILENT;
        endcase
      end else if (state != SILENT && cnt == CNT_MAX) begin
        state <= SILENT;
        cand  <= '0;
        note  <= '0;
        key   <= '0;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// Scoreboard bench: each output event is predicted when its tone_in edge is driven.
module tb_tone_decoder;

  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       tone_in = 1'b0;
  logic [7:0] note;
  logic [3:0] key;
  logic       valid;
  logic       note_strobe;

  tone_decoder #(.TOL(1024), .CNT_W(17)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .tone_in     (tone_in),
    .note        (note),
    .key         (key),
    .valid       (valid),
    .note_strobe (note_strobe)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int at;
    int note;
    int key;
    int valid;
    int strobe;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int vectors = 0;
  int miscompares = 0;
  int last_tog = 0;
  logic [12:0] prev_out = '0;
  int jit[6] = '{500, -500, 437, -499, 250, -123};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  task automatic expect_evt(input int at, input int n, input int k, input int v, input int s);
    exp_t e;
    e.at = at; e.note = n; e.key = k; e.valid = v; e.strobe = s;
    sb.push_back(e);
  endtask

  task automatic toggle_after(input int n);
    repeat (n) @(posedge sysclk);
    #1 tone_in = ~tone_in;
    last_tog = cyc;
  endtask

  // An event is any strobe or any change of note/key/valid.
  always @(negedge sysclk) begin
    if (!reset) begin
      if (note_strobe || {note, key, valid} != prev_out) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_event_cycle", cyc, 0);
        end else begin
          cur = sb.pop_front();
          $display("event @%0d: note=%0d key=%0d valid=%0d strobe=%0d", cyc, note, key, valid, note_strobe);
          check_eq("evt_cycle", cyc, cur.at);
          check_eq("evt_note", note, cur.note);
          check_eq("evt_key", key, cur.key);
          check_eq("evt_valid", valid, cur.valid);
          check_eq("evt_strobe", note_strobe, cur.strobe);
        end
      end
    end
    prev_out = {note, key, valid};
  end

  initial begin
    repeat (5) @(posedge sysclk);
    @(negedge sysclk);
    check_eq("rst_note", note, 0);
    check_eq("rst_key", key, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_strobe", note_strobe, 0);
    @(posedge sysclk);
    #1 reset = 1'b0;

    // Lock on note 31 on the third edge; fourth edge must be silent.
    toggle_after(10);
    toggle_after(87552);
    toggle_after(87552); expect_evt(last_tog + 4, 31, 3, 1, 1);
    toggle_after(87552);

    // Switch to note 25, then to 65536-cycle half-periods (note 36).
    toggle_after(123648); expect_evt(last_tog + 4, 31, 3, 0, 0);
    toggle_after(123648); expect_evt(last_tog + 4, 25, 6, 1, 1);
    toggle_after(65536);  expect_evt(last_tog + 4, 25, 6, 0, 0);
    toggle_after(65536);  expect_evt(last_tog + 4, 36, 12, 1, 1);

    // Jittered note 33: one relock, then no further events.
    for (int i = 0; i < 6; i++) begin
      toggle_after(77824 + jit[i]);
      if (i == 0) expect_evt(last_tog + 4, 36, 12, 0, 0);
      if (i == 1) expect_evt(last_tog + 4, 33, 4, 1, 1);
    end

    // Static input: silence exactly 131071 cycles after the last lock-side update.
    expect_evt(last_tog + 4 + 131071, 0, 0, 0, 0);
    repeat (131080) @(posedge sysclk);

    // Tolerance edges on note 37: +TOL matches, -TOL-1 does not.
    toggle_after(10);
    toggle_after(62848);
    toggle_after(62848); expect_evt(last_tog + 4, 37, 13, 1, 1);
    toggle_after(60799); expect_evt(last_tog + 4, 37, 13, 0, 0);
    toggle_after(60799);
    toggle_after(60799);

    // Relock, then reset at half-count.
    toggle_after(61824);
    toggle_after(61824); expect_evt(last_tog + 4, 37, 13, 1, 1);
    repeat (30912) @(posedge sysclk);
    #1 reset = 1'b1;
    tone_in = 1'b0;
    @(posedge sysclk);
    @(negedge sysclk);
    check_eq("midrst_note", note, 0);
    check_eq("midrst_key", key, 0);
    check_eq("midrst_valid", valid, 0);
    check_eq("midrst_strobe", note_strobe, 0);
    @(posedge sysclk);
    #1 reset = 1'b0;

    toggle_after(20);
    toggle_after(61824);
    toggle_after(61824); expect_evt(last_tog + 4, 37, 13, 1, 1);
    repeat (10) @(posedge sysclk);
    @(negedge sysclk);
    check_eq("pending_events", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
